// File: rtl/ecc_secded_dec_pipe.sv
// ecc_secded_dec_pipe: two-stage SECDED (extended Hamming) decoder with a
// valid/ready handshake and saturating single/double error counters.
// Stage 1 forms the syndrome and the overall-parity mismatch.
// Stage 2 classifies the error, builds the flip mask and corrects the data.
module ecc_secded_dec_pipe #(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] read_bits,
   input  logic [CHK_W-1:0]  read_ecc_bits,
   input  logic              corr_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_o,
   output logic [DATA_W-1:0] ecc_msk_o,
   output logic              ecc_sec,
   output logic              ecc_err_det,
   output logic [CNT_W-1:0]  sec_cnt,
   output logic [CNT_W-1:0]  ded_cnt,
   input  logic              cnt_clr
);

   localparam int R = CHK_W - 1;
   localparam int N = DATA_W + R;
   localparam logic [R-1:0] N_L = R'(N);

   // Check width r+1, where r is the smallest value with 2^r >= DATA_W+r+1.
   function automatic int calc_chk_w(input int dw);
      int r;
      r = 0;
      for (int i = 1; i < 16; i++)
         if (r == 0 && (1 << i) >= dw + i + 1) r = i;
      return r + 1;
   endfunction

   // Codeword position of data bit idx: data fills the non-power-of-two
   // positions in ascending order, LSB first.
   function automatic logic [R-1:0] data_pos(input int idx);
      int cnt;
      logic [R-1:0] res;
      cnt = 0;
      res = '0;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == idx) res = R'(p);
            cnt++;
         end
      end
      return res;
   endfunction

   if (DATA_W < 4 || DATA_W > 128) begin : g_bad_data_w
      $error("ecc_secded_dec_pipe: DATA_W out of range 4..128");
   end
   if (CHK_W != calc_chk_w(DATA_W)) begin : g_bad_chk_w
      $error("ecc_secded_dec_pipe: CHK_W does not match DATA_W");
   end

   logic              stall;
   logic              s1_valid;
   logic [R-1:0]      s1_syn;
   logic              s1_par;
   logic [DATA_W-1:0] s1_data;
   logic              s1_corr;

   logic [R-1:0]      syn_terms [DATA_W];
   logic [R-1:0]      syn_c;
   logic              par_c;
   logic [DATA_W-1:0] mask_c;
   logic              sec_c;
   logic              det_c;
   logic [DATA_W-1:0] data_c;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Per data bit: its syndrome contribution and its mask match.
   for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      localparam logic [R-1:0] POS = data_pos(i);
      assign syn_terms[i] = read_bits[i] ? POS : '0;
      assign mask_c[i]    = s1_par && (s1_syn == POS);
   end

   // Syndrome = recomputed Hamming bits XOR received Hamming bits.
   always_comb begin
      syn_c = read_ecc_bits[R-1:0];
      for (int i = 0; i < DATA_W; i++) syn_c = syn_c ^ syn_terms[i];
   end

   assign par_c = ^{read_bits, read_ecc_bits};

   // Classify the registered syndrome/parity pair into single or uncorrectable.
   always_comb begin
      sec_c = 1'b0;
      det_c = 1'b0;
      if (s1_par) begin
         if (s1_syn > N_L) det_c = 1'b1;
         else              sec_c = 1'b1;
      end else if (s1_syn != '0) begin
         det_c = 1'b1;
      end
   end

   assign data_c = s1_data ^ (s1_corr ? mask_c : '0);

   // Stage 1: capture syndrome, parity mismatch, raw data and mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
         s1_data  <= '0;
         s1_corr  <= 1'b0;
      end else if (!stall) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_syn  <= syn_c;
            s1_par  <= par_c;
            s1_data <= read_bits;
            s1_corr <= corr_en;
         end
      end
   end

   // Stage 2: register the corrected word, mask and error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         data_o      <= '0;
         ecc_msk_o   <= '0;
         ecc_sec     <= 1'b0;
         ecc_err_det <= 1'b0;
      end else if (!stall) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            data_o      <= data_c;
            ecc_msk_o   <= mask_c;
            ecc_sec     <= sec_c;
            ecc_err_det <= det_c;
         end
      end
   end

   // Saturating event counters, bumped on output handshakes; clear wins.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         sec_cnt <= '0;
         ded_cnt <= '0;
      end else if (out_valid && out_ready) begin
         if (ecc_sec && sec_cnt != '1)     sec_cnt <= sec_cnt + CNT_W'(1);
         if (ecc_err_det && ded_cnt != '1) ded_cnt <= ded_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ecc_secded_dec_pipe.sv
// tb_ecc_secded_dec_pipe: directed self-checking bench for the SECDED
// decoder pipeline (DATA_W=32, CHK_W=7, CNT_W=16).
module tb_ecc_secded_dec_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] read_bits;
   logic [6:0]  read_ecc_bits;
   logic        corr_en;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_o;
   logic [31:0] ecc_msk_o;
   logic        ecc_sec;
   logic        ecc_err_det;
   logic [15:0] sec_cnt;
   logic [15:0] ded_cnt;
   logic        cnt_clr;

   int vecCount  = 0;
   int missCount = 0;

   logic [31:0] base;
   logic [6:0]  eb;
   logic [31:0] stallData [10];
   logic [31:0] stallRaw  [10];
   logic [6:0]  stallEcc  [10];
   int          cyc;
   int          sent;
   int          recv;
   logic        stalledPrev;
   logic [31:0] lastData;

   ecc_secded_dec_pipe #(.DATA_W(32), .CHK_W(7), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .read_bits(read_bits), .read_ecc_bits(read_ecc_bits), .corr_en(corr_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_o(data_o), .ecc_msk_o(ecc_msk_o),
      .ecc_sec(ecc_sec), .ecc_err_det(ecc_err_det),
      .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .cnt_clr(cnt_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference encoder: builds codeword positions 1..38 and derives check bits.
   function automatic logic [6:0] encodeEcc(input logic [31:0] d);
      logic [38:0] cw;
      logic [6:0]  e;
      int          di;
      cw = '0;
      di = 0;
      for (int pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos] = d[di];
            di++;
         end
      end
      e = '0;
      for (int k = 0; k < 6; k++)
         for (int pos = 1; pos <= 38; pos++)
            if (((pos >> k) & 1) != 0) e[k] = e[k] ^ cw[pos];
      e[6] = (^d) ^ (^e[5:0]);
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sends one word and returns at the negedge where its output is visible.
   task automatic applyStimulus(input logic [31:0] d, input logic [6:0] e, input logic c);
      @(posedge clk);
      #1;
      in_valid      = 1'b1;
      read_bits     = d;
      read_ecc_bits = e;
      corr_en       = c;
      out_ready     = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("latency_one_cycle_valid", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("latency_two_cycle_valid", out_valid, 1);
   endtask

   task automatic nextCycle;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; read_bits = '0; read_ecc_bits = '0;
      corr_en = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_data_o", data_o, 0);
      checkOutput("reset_mask", ecc_msk_o, 0);
      checkOutput("reset_sec", ecc_sec, 0);
      checkOutput("reset_err_det", ecc_err_det, 0);
      checkOutput("reset_sec_cnt", sec_cnt, 0);
      checkOutput("reset_ded_cnt", ded_cnt, 0);
      checkOutput("reset_in_ready", in_ready, 1);

      base = 32'hDEADBEEF;
      eb   = encodeEcc(base);

      applyStimulus(base, eb, 1'b1);
      checkOutput("clean_data", data_o, 32'hDEADBEEF);
      checkOutput("clean_mask", ecc_msk_o, 0);
      checkOutput("clean_sec", ecc_sec, 0);
      checkOutput("clean_det", ecc_err_det, 0);

      applyStimulus(base ^ 32'h1, eb, 1'b1);
      checkOutput("bit0_data", data_o, 32'hDEADBEEF);
      checkOutput("bit0_mask", ecc_msk_o, 32'h1);
      checkOutput("bit0_sec", ecc_sec, 1);
      checkOutput("bit0_det", ecc_err_det, 0);
      nextCycle();
      checkOutput("bit0_sec_cnt", sec_cnt, 1);

      applyStimulus(base ^ 32'h3, eb, 1'b1);
      checkOutput("double_data", data_o, 32'hDEADBEEC);
      checkOutput("double_mask", ecc_msk_o, 0);
      checkOutput("double_sec", ecc_sec, 0);
      checkOutput("double_det", ecc_err_det, 1);
      nextCycle();
      checkOutput("double_ded_cnt", ded_cnt, 1);

      applyStimulus(base ^ 32'h1, eb, 1'b0);
      checkOutput("detonly_data", data_o, 32'hDEADBEEE);
      checkOutput("detonly_mask", ecc_msk_o, 32'h1);
      checkOutput("detonly_sec", ecc_sec, 1);

      applyStimulus(base ^ 32'h80000000, eb, 1'b1);
      checkOutput("bit31_data", data_o, 32'hDEADBEEF);
      checkOutput("bit31_mask", ecc_msk_o, 32'h80000000);
      checkOutput("bit31_sec", ecc_sec, 1);

      applyStimulus(base, eb ^ 7'h04, 1'b1);
      checkOutput("chkbit_data", data_o, 32'hDEADBEEF);
      checkOutput("chkbit_mask", ecc_msk_o, 0);
      checkOutput("chkbit_sec", ecc_sec, 1);
      checkOutput("chkbit_det", ecc_err_det, 0);

      applyStimulus(base, eb ^ 7'h40, 1'b1);
      checkOutput("parbit_data", data_o, 32'hDEADBEEF);
      checkOutput("parbit_mask", ecc_msk_o, 0);
      checkOutput("parbit_sec", ecc_sec, 1);

      applyStimulus(base, eb ^ 7'h7F, 1'b1);
      checkOutput("invalid_data", data_o, 32'hDEADBEEF);
      checkOutput("invalid_mask", ecc_msk_o, 0);
      checkOutput("invalid_sec", ecc_sec, 0);
      checkOutput("invalid_det", ecc_err_det, 1);
      nextCycle();
      checkOutput("directed_sec_cnt", sec_cnt, 5);
      checkOutput("directed_ded_cnt", ded_cnt, 2);

      // Back-to-back stream with a three-cycle downstream stall.
      for (int k = 0; k < 10; k++) begin
         stallData[k] = 32'h0F1E2D3C + k * 32'h11110001;
         stallEcc[k]  = encodeEcc(stallData[k]);
         stallRaw[k]  = (k % 2 == 1) ? (stallData[k] ^ (32'h1 << (k * 3))) : stallData[k];
      end
      cyc = 0; sent = 0; recv = 0; stalledPrev = 1'b0; lastData = '0;
      while (recv < 10 && cyc < 60) begin
         @(posedge clk);
         #1;
         out_ready = !(cyc >= 3 && cyc <= 5);
         corr_en   = 1'b1;
         if (sent < 10) begin
            in_valid      = 1'b1;
            read_bits     = stallRaw[sent];
            read_ecc_bits = stallEcc[sent];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (stalledPrev) checkOutput("stall_data_stable", data_o, lastData);
         if (out_valid && !out_ready) checkOutput("stall_in_ready", in_ready, 0);
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            checkOutput("stream_data", data_o, stallData[recv]);
            checkOutput("stream_sec", ecc_sec, (recv % 2 == 1) ? 1 : 0);
            recv++;
         end
         stalledPrev = out_valid && !out_ready;
         lastData    = data_o;
         cyc++;
      end
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
      checkOutput("stream_recv_count", recv, 10);
      checkOutput("stream_sent_count", sent, 10);
      repeat (3) nextCycle();
      checkOutput("stream_drained", out_valid, 0);
      checkOutput("stream_sec_cnt", sec_cnt, 10);

      // Reset while a word is in flight discards it.
      @(posedge clk);
      #1;
      in_valid = 1'b1; read_bits = base ^ 32'h1; read_ecc_bits = eb;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_in_ready", in_ready, 1);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_data_o", data_o, 0);
      checkOutput("midrst_sec_cnt", sec_cnt, 0);
      nextCycle();
      checkOutput("midrst_discarded", out_valid, 0);

      // Saturation: 65535 single errors reach the top value.
      @(posedge clk);
      #1;
      in_valid = 1'b1; read_bits = base ^ 32'h1; read_ecc_bits = eb;
      corr_en = 1'b1; out_ready = 1'b1;
      repeat (65535) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_reach_max", sec_cnt, 16'hFFFF);
      applyStimulus(base ^ 32'h1, eb, 1'b1);
      nextCycle();
      checkOutput("sat_hold_max", sec_cnt, 16'hFFFF);

      // Clear coinciding with an error handshake leaves the counter at zero.
      applyStimulus(base ^ 32'h1, eb, 1'b1);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      @(negedge clk);
      checkOutput("clr_wins_sec_cnt", sec_cnt, 0);
      checkOutput("clr_wins_ded_cnt", ded_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
